// File: rtl/hazard_controller.sv
`default_nettype none
// ============================================================================
// Module   : hazard_controller
// Brief    : Pipeline sequencing for the 3-stage RV32I core. Drives stall and
//            flush controls, branch redirect and operand forwarding, freezes
//            the pipeline on slow data-memory accesses with a timeout/recovery
//            sequence, and counts stalled cycles.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_controller #(
    parameter int TIMEOUT = 16              // legal range 2..255
) (
    input  logic        clk,
    input  logic        rst,                // asynchronous, active-low
    input  logic [4:0]  rs1_D,
    input  logic [4:0]  rs2_D,
    input  logic [4:0]  rd_M,
    input  logic        reg_wr_M,
    input  logic        mem_req_M,
    input  logic        dmem_ready,
    input  logic        br_taken_E,
    input  logic        err_clr,
    output logic        StallF,
    output logic        StallD,
    output logic        StallM,
    output logic        FlushD,
    output logic        FlushM,
    output logic        pc_redirect,
    output logic        fwd_a,
    output logic        fwd_b,
    output logic        mem_err,
    output logic [15:0] stall_cnt
);

    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_WAIT    = 2'd1,
        S_ERR     = 2'd2,
        S_RECOVER = 2'd3
    } state_t;

    // Last wait count before the access is declared timed out; with the first
    // stalled cycle loading 1, this yields exactly TIMEOUT stalled cycles.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic        mem_err_q, mem_err_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    logic        mem_stall;
    logic        stall_all;
    logic        flush_dec;
    logic        flush_mem;
    logic        redirect;

    // Next-state and control decode; stall always masks branch flush/redirect
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        mem_err_d  = mem_err_q;
        stall_all  = 1'b0;
        flush_dec  = 1'b0;
        flush_mem  = 1'b0;
        redirect   = 1'b0;
        mem_stall  = ((state_q == S_RUN)  && mem_req_M && !dmem_ready) ||
                     ((state_q == S_WAIT) && !dmem_ready);

        case (state_q)
            S_RUN: begin
                if (mem_stall) begin
                    stall_all  = 1'b1;
                    state_d    = S_WAIT;
                    wait_cnt_d = 8'd1;
                end else if (br_taken_E) begin
                    flush_dec = 1'b1;
                    redirect  = 1'b1;
                end
            end
            S_WAIT: begin
                if (!mem_stall) begin
                    // Release cycle: a frozen branch resolves right away
                    state_d    = S_RUN;
                    wait_cnt_d = 8'd0;
                    if (br_taken_E) begin
                        flush_dec = 1'b1;
                        redirect  = 1'b1;
                    end
                end else begin
                    stall_all = 1'b1;
                    if (wait_cnt_q == WAIT_LAST) begin
                        state_d    = S_ERR;
                        mem_err_d  = 1'b1;
                        wait_cnt_d = 8'd0;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 8'd1;
                    end
                end
            end
            S_ERR: begin
                // Memory response is no longer trusted; only err_clr exits
                stall_all = 1'b1;
                if (err_clr) begin
                    state_d = S_RECOVER;
                end
            end
            S_RECOVER: begin
                // Squash whatever sits in Fetch/Decode and Decode/Memory
                flush_dec = 1'b1;
                flush_mem = 1'b1;
                state_d   = S_RUN;
            end
            default: begin
                state_d = S_RUN;
            end
        endcase

        stall_cnt_d = stall_cnt_q;
        if (stall_all && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    // State, wait counter, sticky error flag and stall counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_RUN;
            wait_cnt_q  <= 8'd0;
            mem_err_q   <= 1'b0;
            stall_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_err_q   <= mem_err_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Combinational outputs are held low while reset is asserted
    assign StallF      = rst & stall_all;
    assign StallD      = rst & stall_all;
    assign StallM      = rst & stall_all;
    assign FlushD      = rst & flush_dec;
    assign FlushM      = rst & flush_mem;
    assign pc_redirect = rst & redirect;
    assign fwd_a       = rst & reg_wr_M & (rd_M != 5'd0) & (rd_M == rs1_D);
    assign fwd_b       = rst & reg_wr_M & (rd_M != 5'd0) & (rd_M == rs2_D);
    assign mem_err     = mem_err_q;
    assign stall_cnt   = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_controller
// Brief    : Self-checking bench for hazard_controller: vector table,
//            directed multi-cycle sequences and randomized traffic against a
//            behavioural reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_controller;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs1_D, rs2_D, rd_M;
    logic        reg_wr_M, mem_req_M, dmem_ready, br_taken_E, err_clr;
    logic        StallF, StallD, StallM, FlushD, FlushM, pc_redirect;
    logic        fwd_a, fwd_b, mem_err;
    logic [15:0] stall_cnt;

    hazard_controller #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .rs1_D(rs1_D), .rs2_D(rs2_D), .rd_M(rd_M),
        .reg_wr_M(reg_wr_M), .mem_req_M(mem_req_M), .dmem_ready(dmem_ready),
        .br_taken_E(br_taken_E), .err_clr(err_clr),
        .StallF(StallF), .StallD(StallD), .StallM(StallM),
        .FlushD(FlushD), .FlushM(FlushM), .pc_redirect(pc_redirect),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_err(mem_err), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: how many cycles the current access has been stalled,
    // whether we are latched in timeout, and whether a recovery is due now.
    int m_waited;
    bit m_in_err;
    bit m_recover;
    bit m_err_flag;
    int m_stall_cnt;

    typedef struct {
        logic [4:0] rs1, rs2, rd;
        logic       wr, br;
        logic       e_fa, e_fb, e_fd, e_pr;
    } vec_t;
    vec_t vecs[8];

    int n_st;
    int ready_pct;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [8:0] outs();
        return {StallF, StallD, StallM, FlushD, FlushM, pc_redirect, fwd_a, fwd_b, mem_err};
    endfunction

    function automatic bit model_stall();
        if (m_in_err)  return 1'b1;
        if (m_recover) return 1'b0;
        return (m_waited > 0 || mem_req_M) && !dmem_ready;
    endfunction

    function automatic logic [8:0] model_outs();
        bit st, fd, fm, pr, fa, fb;
        st = model_stall();
        fm = m_recover;
        pr = !m_recover && !m_in_err && !st && br_taken_E;
        fd = m_recover || pr;
        fa = reg_wr_M && rd_M != 0 && rd_M == rs1_D;
        fb = reg_wr_M && rd_M != 0 && rd_M == rs2_D;
        return {st, st, st, fd, fm, pr, fa, fb, m_err_flag};
    endfunction

    task automatic model_reset();
        m_waited = 0; m_in_err = 0; m_recover = 0; m_err_flag = 0; m_stall_cnt = 0;
    endtask

    task automatic model_advance();
        bit st;
        st = model_stall();
        if (st && m_stall_cnt < 16'hFFFF) m_stall_cnt++;
        if (m_recover) begin
            m_recover = 0;
        end else if (m_in_err) begin
            if (err_clr) begin m_in_err = 0; m_recover = 1; end
        end else if (st) begin
            m_waited++;
            if (m_waited == TIMEOUT) begin
                m_in_err = 1; m_err_flag = 1; m_waited = 0;
            end
        end else begin
            m_waited = 0;
        end
    endtask

    // Called at posedge+1: move to mid-cycle and compare against the model
    task automatic sample(input string name);
        #4;
        check({name, "_outs"}, 32'(outs()), 32'(model_outs()));
        check({name, "_cnt"}, 32'(stall_cnt), 32'(m_stall_cnt));
        check({name, "_excl"}, 32'(FlushD & StallD), 32'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        model_advance();
        #1;
    endtask

    task automatic step(input string name);
        sample(name);
        tick();
    endtask

    task automatic idle_inputs();
        rs1_D = 0; rs2_D = 0; rd_M = 0; reg_wr_M = 0;
        mem_req_M = 0; dmem_ready = 1; br_taken_E = 0; err_clr = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{5'd5,  5'd0,  5'd5,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{5'd5,  5'd0,  5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{5'd7,  5'd7,  5'd7,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{5'd7,  5'd7,  5'd7,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{5'd3,  5'd9,  5'd9,  1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[5] = '{5'd0,  5'd0,  5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{5'd31, 5'd30, 5'd30, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[7] = '{5'd12, 5'd12, 5'd13, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        // Reset: everything low even with hazard-provoking inputs
        idle_inputs();
        rst = 1'b0;
        reg_wr_M = 1; rd_M = 5; rs1_D = 5; mem_req_M = 1; dmem_ready = 0; br_taken_E = 1;
        model_reset();
        #3;
        check("reset_outs", 32'(outs()), 32'd0);
        check("reset_cnt", 32'(stall_cnt), 32'd0);
        @(posedge clk); #1;
        idle_inputs();
        rst = 1'b1;

        // Forwarding / branch vectors in RUN with no memory traffic
        for (int i = 0; i < 8; i++) begin
            rs1_D = vecs[i].rs1; rs2_D = vecs[i].rs2; rd_M = vecs[i].rd;
            reg_wr_M = vecs[i].wr; br_taken_E = vecs[i].br;
            #4;
            check($sformatf("vec%0d", i),
                  32'({fwd_a, fwd_b, FlushD, pc_redirect, StallD}),
                  32'({vecs[i].e_fa, vecs[i].e_fb, vecs[i].e_fd, vecs[i].e_pr, 1'b0}));
            tick();
        end
        idle_inputs();

        // Ready arriving 3 cycles late stalls exactly 3 cycles
        mem_req_M = 1; dmem_ready = 0;
        for (int i = 0; i < 3; i++) step("wait3");
        dmem_ready = 1;
        sample("wait3_rel");
        check("wait3_rel_stall", 32'(StallF), 32'd0);
        tick();
        mem_req_M = 0;
        check("wait3_cnt", 32'(stall_cnt), 32'd3);
        check("wait3_err", 32'(mem_err), 32'd0);

        // Ready in the first cycle: no stall at all
        mem_req_M = 1; dmem_ready = 1;
        sample("fast");
        check("fast_stall", 32'(StallF), 32'd0);
        tick();

        // Branch during a 2-cycle wait resolves in the release cycle
        mem_req_M = 1; dmem_ready = 0; br_taken_E = 1;
        for (int i = 0; i < 2; i++) begin
            sample("brwait");
            check("brwait_noflush", 32'({FlushD, pc_redirect, StallD}), 32'b001);
            tick();
        end
        dmem_ready = 1;
        sample("brrel");
        check("brrel_flush", 32'({FlushD, pc_redirect, StallD}), 32'b110);
        tick();
        idle_inputs();

        // Timeout: TIMEOUT stalled cycles, then ERR ignoring dmem_ready
        mem_req_M = 1; dmem_ready = 0;
        n_st = 0;
        for (int i = 0; i < TIMEOUT; i++) begin
            sample("tmo");
            n_st += int'(StallF);
            tick();
        end
        check("tmo_stalls", 32'(n_st), 32'(TIMEOUT));
        dmem_ready = 1;
        sample("err_hold");
        check("err_hold_flags", 32'({StallF, mem_err}), 32'b11);
        tick();
        err_clr = 1;
        step("err_clr");
        err_clr = 0; br_taken_E = 1;
        sample("recover");
        check("recover_flags", 32'({StallF, FlushD, FlushM, pc_redirect}), 32'b0110);
        tick();
        idle_inputs();
        sample("after_rec");
        check("after_rec_err", 32'(mem_err), 32'd1);
        tick();

        // Reset in the middle of a wait
        mem_req_M = 1; dmem_ready = 0;
        for (int i = 0; i < 4; i++) step("prerst");
        #2;
        rst = 1'b0;
        #1;
        check("midrst_outs", 32'(outs()), 32'd0);
        check("midrst_cnt", 32'(stall_cnt), 32'd0);
        model_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        idle_inputs();
        step("postrst");
        mem_req_M = 1; dmem_ready = 1;
        sample("postrst_req");
        check("postrst_nostall", 32'(StallF), 32'd0);
        tick();

        // Randomized traffic against the model
        ready_pct = 50;
        for (int i = 0; i < 3000; i++) begin
            if (i % 64 == 0) begin
                case ($urandom_range(0, 2))
                    0: ready_pct = 8;
                    1: ready_pct = 50;
                    default: ready_pct = 90;
                endcase
            end
            rs1_D      = 5'($urandom_range(0, 3));
            rs2_D      = 5'($urandom_range(0, 3));
            rd_M       = 5'($urandom_range(0, 3));
            reg_wr_M   = 1'($urandom_range(0, 1));
            mem_req_M  = 1'($urandom_range(0, 1));
            dmem_ready = ($urandom_range(0, 99) < ready_pct);
            br_taken_E = ($urandom_range(0, 3) == 0);
            err_clr    = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 499) == 0) begin
                rst = 1'b0;
                #1;
                check("rnd_rst", 32'({outs(), stall_cnt}), 32'd0);
                model_reset();
                @(posedge clk); #1;
                rst = 1'b1;
            end else begin
                step("rnd");
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
